amber48_uart_tx_fifo: RTL and testbench

Byte FIFO that sits directly upstream of the UART transmitter. It accepts bytes from the peripheral register/bus side and presents them to the transmitter through a valid/ready handshake: tx_data_o/tx_valid_o feed the transmitter's data_i/valid_i, and tx_ready_i is driven from its ready_o. It decouples CPU writes from the serial bit rate and reports fill level, a low-water condition and a sticky overflow flag.

---
 rtl/amber48_uart_pkg.sv | 9 +
 rtl/amber48_uart_tx_fifo.sv | 117 +++++++++++
 tb/tb_amber48_uart_tx_fifo.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amber48_uart_pkg.sv
// Shared types and defaults for the amber48 UART blocks.
package amber48_uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_TX_FIFO_DEPTH_DEFAULT     = 16;
  localparam int UART_TX_FIFO_LOW_WATER_DEFAULT = 4;

endpackage

// File: rtl/amber48_uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter with first-word fall-through.
// Define AMBER48_UART_TX_FIFO_STATS_EN to add the tx_count_o / drop_count_o counters.
module amber48_uart_tx_fifo
  import amber48_uart_pkg::*;
#(
  parameter int DEPTH     = UART_TX_FIFO_DEPTH_DEFAULT,
  parameter int LOW_WATER = UART_TX_FIFO_LOW_WATER_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [7:0]               wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  input  logic                     flush_i,
  input  logic                     clr_overflow_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     low_water_o,
`ifdef AMBER48_UART_TX_FIFO_STATS_EN
  output logic [31:0]              tx_count_o,
  output logic [15:0]              drop_count_o,
`endif
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LOW_WATER > DEPTH)) begin : g_bad_params
    $fatal(1, "amber48_uart_tx_fifo: DEPTH must be a power of two >= 2 and LOW_WATER <= DEPTH");
  end

  uart_byte_t        r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_rd;
  logic              w_drop;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; ready/valid here depend only on registered level, so a
  // full FIFO refuses a write even when the same edge also pops a byte.
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_wr    = wr_valid_i && !w_full;
  assign w_rd    = tx_ready_i && !w_empty;
  assign w_drop  = wr_valid_i && w_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr && !flush_i) r_mem[r_wr_ptr] <= wr_data_i;
  end

  // Set beats clear when both happen on the same edge; flush leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             r_overflow <= 1'b0;
    else if (w_drop)         r_overflow <= 1'b1;
    else if (clr_overflow_i) r_overflow <= 1'b0;
  end

`ifdef AMBER48_UART_TX_FIFO_STATS_EN
  logic [31:0] r_tx_count;
  logic [15:0] r_drop_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_rd && !flush_i) r_tx_count <= r_tx_count + 32'd1;
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign tx_count_o   = r_tx_count;
  assign drop_count_o = r_drop_count;
`endif

  // The array is not reset, so the head byte is masked to zero while empty.
  assign tx_data_o   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign tx_valid_o  = !w_empty;
  assign wr_ready_o  = !w_full;
  assign level_o     = r_level;
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign low_water_o = (r_level <= LW'(LOW_WATER));
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_amber48_uart_tx_fifo.sv
// Directed bench for amber48_uart_tx_fifo with a queue-based reference model
// and a simple bench-side UART transmitter/decoder for the end-to-end case.
module tb_amber48_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int LOW_WATER = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;

  logic       wr_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic [4:0] level_o;
  logic       empty_o;
  logic       full_o;
  logic       low_water_o;
  logic       overflow_o;
`ifdef AMBER48_UART_TX_FIFO_STATS_EN
  logic [31:0] tx_count_o;
  logic [15:0] drop_count_o;
`endif

  amber48_uart_tx_fifo #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wr_data_i      (wr_data),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready_o),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready),
    .flush_i        (flush),
    .clr_overflow_i (clr_ovf),
    .level_o        (level_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .low_water_o    (low_water_o),
`ifdef AMBER48_UART_TX_FIFO_STATS_EN
    .tx_count_o     (tx_count_o),
    .drop_count_o   (drop_count_o),
`endif
    .overflow_o     (overflow_o)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] dut_log[$];
  logic [7:0] dec_q[$];
  logic       m_ovf = 1'b0;
  int         m_txc = 0;
  int         m_drop = 0;

  // bench-side transmitter and line decoder
  logic       uart_en = 1'b0;
  logic       hs_v = 1'b0;
  logic [7:0] hs_d = '0;
  logic       u_busy = 1'b0;
  logic [9:0] u_frame = '1;
  logic       u_line = 1'b1;
  int         u_clk = 0;
  int         u_bit = 0;
  logic       d_prev = 1'b1;
  logic       d_active = 1'b0;
  int         d_cnt = 0;
  logic [7:0] d_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_txc = 0;
    m_drop = 0;
    u_busy = 1'b0;
    u_line = 1'b1;
    u_clk = 0;
    u_bit = 0;
    d_active = 1'b0;
    d_prev = 1'b1;
  endtask

  task automatic model_update();
    bit m_full;
    bit m_empty;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_full  = (exp_q.size() == DEPTH);
      m_empty = (exp_q.size() == 0);
      if (wr_valid && m_full) begin
        m_ovf = 1'b1;
        if (m_drop < 16'hFFFF) m_drop++;
      end else if (clr_ovf) begin
        m_ovf = 1'b0;
      end
      if (!flush) begin
        if (tx_ready && !m_empty) begin
          void'(exp_q.pop_front());
          m_txc++;
        end
        if (wr_valid && !m_full) exp_q.push_back(wr_data);
      end else begin
        exp_q.delete();
      end
    end
  endtask

  task automatic uart_update();
    int k;
    if (uart_en && rst_n) begin
      if (u_busy) begin
        u_clk++;
        if (u_clk == 10) begin
          u_clk = 0;
          u_bit++;
          if (u_bit == 10) u_busy = 1'b0;
        end
      end else if (hs_v) begin
        u_frame = {1'b1, hs_d, 1'b0};
        u_busy = 1'b1;
        u_bit = 0;
        u_clk = 0;
      end
      u_line = u_busy ? u_frame[u_bit] : 1'b1;
      if (!d_active) begin
        if (d_prev && !u_line) begin
          d_active = 1'b1;
          d_cnt = 0;
        end
      end else begin
        d_cnt++;
        if (d_cnt % 10 == 5) begin
          k = d_cnt / 10;
          if (k == 0) check("start_bit", {31'd0, u_line}, 32'd0);
          else if (k <= 8) d_byte[k-1] = u_line;
          else begin
            check("stop_bit", {31'd0, u_line}, 32'd1);
            dec_q.push_back(d_byte);
            d_active = 1'b0;
          end
        end
      end
      d_prev = u_line;
    end
  endtask

  // One clock: capture handshake at the falling edge, update models at the
  // rising edge, return 1 time unit after it so new inputs can be applied.
  task automatic step();
    @(negedge clk);
    hs_v = tx_valid_o && tx_ready && !flush && rst_n;
    hs_d = tx_data_o;
    if (hs_v) dut_log.push_back(tx_data_o);
    @(posedge clk);
    model_update();
    uart_update();
    #1;
    if (uart_en) tx_ready = !u_busy;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},    {27'd0, level_o},     32'd0);
    check({tag, "_empty"},    {31'd0, empty_o},     32'd1);
    check({tag, "_full"},     {31'd0, full_o},      32'd0);
    check({tag, "_tx_valid"}, {31'd0, tx_valid_o},  32'd0);
    check({tag, "_wr_ready"}, {31'd0, wr_ready_o},  32'd1);
    check({tag, "_low"},      {31'd0, low_water_o}, 32'd1);
    check({tag, "_ovf"},      {31'd0, overflow_o},  32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data_o},   32'd0);
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    check("cmp_level",    {27'd0, level_o},     exp_q.size());
    check("cmp_empty",    {31'd0, empty_o},     {31'd0, exp_q.size() == 0});
    check("cmp_full",     {31'd0, full_o},      {31'd0, exp_q.size() == DEPTH});
    check("cmp_low",      {31'd0, low_water_o}, {31'd0, exp_q.size() <= LOW_WATER});
    check("cmp_wr_ready", {31'd0, wr_ready_o},  {31'd0, exp_q.size() != DEPTH});
    check("cmp_tx_valid", {31'd0, tx_valid_o},  {31'd0, exp_q.size() != 0});
    check("cmp_ovf",      {31'd0, overflow_o},  {31'd0, m_ovf});
    if (exp_q.size() != 0) check("cmp_tx_data", {24'd0, tx_data_o}, {24'd0, exp_q[0]});
`ifdef AMBER48_UART_TX_FIFO_STATS_EN
    check("cmp_tx_count",   tx_count_o,           m_txc);
    check("cmp_drop_count", {16'd0, drop_count_o}, m_drop);
`endif
  end

  // ---------------- directed stimulus ----------------
  initial begin
    step();
    step();
    check_reset_values("rst");
    rst_n = 1'b1;

    // single byte fall-through, then consume
    wr(8'h41);
    check("t1_valid", {31'd0, tx_valid_o},  32'd1);
    check("t1_data",  {24'd0, tx_data_o},   32'h41);
    check("t1_level", {27'd0, level_o},     32'd1);
    check("t1_empty", {31'd0, empty_o},     32'd0);
    check("t1_low",   {31'd0, low_water_o}, 32'd1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("t1_level_after", {27'd0, level_o}, 32'd0);
    check("t1_empty_after", {31'd0, empty_o}, 32'd1);

    // fill, overflow, drain in order
    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'hAA);
    check("t2_full",     {31'd0, full_o},     32'd1);
    check("t2_wr_ready", {31'd0, wr_ready_o}, 32'd0);
    check("t2_ovf",      {31'd0, overflow_o}, 32'd1);
    check("t2_level",    {27'd0, level_o},    32'd16);
    dut_log.delete();
    tx_ready = 1'b1;
    repeat (16) step();
    tx_ready = 1'b0;
    check("t2_drain_count", dut_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < dut_log.size(); i++)
      check("t2_drain_byte", {24'd0, dut_log[i]}, i);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t2_ovf_clr", {31'd0, overflow_o}, 32'd0);

    // steady write+read across pointer wrap
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    dut_log.delete();
    wr_valid = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'h20 + 8'(i);
      step();
      check("t3_level", {27'd0, level_o}, 32'd8);
    end
    wr_valid = 1'b0;
    repeat (8) step();
    tx_ready = 1'b0;
    check("t3_count", dut_log.size(), 32'd28);
    for (int i = 0; i < 28 && i < dut_log.size(); i++)
      check("t3_order", {24'd0, dut_log[i]}, (i < 8) ? (32'h10 + i) : (32'h20 + i - 8));

    // full with simultaneous write and read
    for (int i = 0; i < 16; i++) wr(8'h30 + 8'(i));
    wr_valid = 1'b1;
    wr_data = 8'hEE;
    tx_ready = 1'b1;
    step();
    wr_valid = 1'b0;
    tx_ready = 1'b0;
    check("t4_level", {27'd0, level_o},    32'd15);
    check("t4_ovf",   {31'd0, overflow_o}, 32'd1);
    check("t4_full",  {31'd0, full_o},     32'd0);
    check("t4_head",  {24'd0, tx_data_o},  32'h31);

    // flush with simultaneous write
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
    flush = 1'b1;
    wr_valid = 1'b1;
    wr_data = 8'h77;
    step();
    flush = 1'b0;
    wr_valid = 1'b0;
    check("t5_level", {27'd0, level_o},    32'd0);
    check("t5_valid", {31'd0, tx_valid_o}, 32'd0);
    check("t5_ovf",   {31'd0, overflow_o}, 32'd1);
    step();
    check("t5_level_hold", {27'd0, level_o}, 32'd0);

    // asynchronous reset with 3 bytes queued
    for (int i = 0; i < 3; i++) wr(8'h60 + 8'(i));
    check("t6_level_pre", {27'd0, level_o}, 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("arst");
    step();
    step();
    rst_n = 1'b1;

    // end-to-end through the bench transmitter
    uart_en = 1'b1;
    tx_ready = 1'b1;
    dec_q.delete();
    wr(8'h55);
    wr(8'hA3);
    for (int i = 0; i < 400 && dec_q.size() < 2; i++) step();
    repeat (30) step();
    check("t7_frames", dec_q.size(), 32'd2);
    if (dec_q.size() >= 2) begin
      check("t7_byte0", {24'd0, dec_q[0]}, 32'h55);
      check("t7_byte1", {24'd0, dec_q[1]}, 32'hA3);
    end
    check("t7_level", {27'd0, level_o}, 32'd0);
    uart_en = 1'b0;
    tx_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
